// File: rtl/button_input_ctrl.sv
// button_input_ctrl: front end for the alarm-clock front-panel buttons.
// Synchronizes the raw pins, debounces them on a shared sample tick, and turns
// debounced levels into press, long-press and auto-repeat pulses. One hold/repeat
// timer is shared between buttons; the first newly pressed button owns it.
module button_input_ctrl #(
    parameter int NUM_BTN   = 4,
    parameter int TICK_DIV  = 100000,
    parameter int DEB_LEN   = 10,
    parameter int HOLD_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_BTN-1:0]         btn_raw,
    input  logic                       enable,
    output logic                       tick_1ms,
    output logic [NUM_BTN-1:0]         btn_level,
    output logic [NUM_BTN-1:0]         btn_press,
    output logic [NUM_BTN-1:0]         btn_long,
    output logic [NUM_BTN-1:0]         btn_repeat,
    output logic                       busy,
    output logic [$clog2(NUM_BTN)-1:0] owner_idx
);

    localparam int TW   = $clog2(TICK_DIV);
    localparam int HMAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int CW   = $clog2(HMAX);
    localparam int OW   = $clog2(NUM_BTN);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [NUM_BTN-1:0]              sync1_q;
    logic [NUM_BTN-1:0]              btn_s_q;
    logic [TW-1:0]                   tick_cnt_q, tick_cnt_d;
    logic                            tick;
    logic [NUM_BTN-1:0][DEB_LEN-1:0] sh_q, sh_d;
    logic [NUM_BTN-1:0]              level_q, level_d;
    logic [NUM_BTN-1:0]              press_q, press_d;
    logic [NUM_BTN-1:0]              long_q, long_d;
    logic [NUM_BTN-1:0]              rep_q, rep_d;
    logic [1:0]                      state_q, state_d;
    logic [OW-1:0]                   owner_q, owner_d;
    logic [OW-1:0]                   first_idx;
    logic [CW-1:0]                   hold_cnt_q, hold_cnt_d;

    // Two-flop synchronizer for the asynchronous button pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            btn_s_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            btn_s_q <= sync1_q;
        end
    end

    // Sample-tick divider; parked at zero while disabled so no tick can fire
    assign tick = enable && (tick_cnt_q == TW'(TICK_DIV - 1));

    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        if (!enable || tick) begin
            tick_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Debounce shift on tick; level has hysteresis (all ones sets, all zeros clears)
    always_comb begin
        sh_d    = sh_q;
        level_d = level_q;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (tick) begin
                sh_d[i] = {sh_q[i][DEB_LEN-2:0], btn_s_q[i]};
            end
            if (enable) begin
                if (&sh_q[i]) begin
                    level_d[i] = 1'b1;
                end else if (~|sh_q[i]) begin
                    level_d[i] = 1'b0;
                end
            end
        end
        press_d = enable ? (level_d & ~level_q) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q    <= '0;
            level_q <= '0;
            press_q <= '0;
        end else begin
            sh_q    <= sh_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    // Lowest-index button among this cycle's new presses
    always_comb begin
        first_idx = '0;
        for (int unsigned i = NUM_BTN; i > 0; i--) begin
            if (press_d[i-1]) begin
                first_idx = OW'(i - 1);
            end
        end
    end

    // Hold/repeat arbiter. It acts on next-state press/level so ownership and
    // release line up with the edge where btn_press/btn_level change.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        long_d     = '0;
        rep_d      = '0;
        if (!enable) begin
            state_d    = ST_IDLE;
            owner_d    = '0;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|press_d) begin
                        state_d    = ST_HOLD;
                        owner_d    = first_idx;
                        hold_cnt_d = '0;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (!level_d[owner_q]) begin
                        state_d    = ST_IDLE;
                        owner_d    = '0;
                        hold_cnt_d = '0;
                    end else if (tick) begin
                        if (state_q == ST_HOLD) begin
                            if (hold_cnt_q == CW'(HOLD_MS - 1)) begin
                                long_d[owner_q] = 1'b1;
                                hold_cnt_d      = '0;
                                state_d         = ST_REPEAT;
                            end else begin
                                hold_cnt_d = hold_cnt_q + 1'b1;
                            end
                        end else begin
                            if (hold_cnt_q == CW'(REPEAT_MS - 1)) begin
                                rep_d[owner_q] = 1'b1;
                                hold_cnt_d     = '0;
                            end else begin
                                hold_cnt_d = hold_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    owner_d    = '0;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            hold_cnt_q <= '0;
            long_q     <= '0;
            rep_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            long_q     <= long_d;
            rep_q      <= rep_d;
        end
    end

    assign tick_1ms   = tick;
    assign btn_level  = level_q;
    assign btn_press  = press_q;
    assign btn_long   = long_q;
    assign btn_repeat = rep_q;
    assign busy       = (state_q != ST_IDLE);
    assign owner_idx  = owner_q;

endmodule
